// File: rtl/alu_issue.sv
// alu_issue: RV32I ALU decode stage with a 2-entry skid buffer between fetch and EX.
// Payload is {illegal, wen, rd, fn, src2, src1}; illegal ops issue with an all-zero payload.
module alu_issue #(
  parameter int XLEN = 32,
  parameter bit SKID = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_src1,
  output logic [XLEN-1:0] ex_src2,
  output logic [5:0]      ex_fn,
  output logic [4:0]      ex_rd,
  output logic            ex_wen,
  output logic            ex_illegal
);
  localparam int PW = 2*XLEN+13;
  localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2;
  logic [1:0]      r_state, w_next;
  logic [PW-1:0]   r_out, r_skid, w_dec;
  logic [6:0]      w_opc, w_f7;
  logic [2:0]      w_f3;
  logic [5:0]      w_alu_fn, w_fn;
  logic [XLEN-1:0] w_src1, w_src2;
  logic w_is_op, w_is_imm, w_is_lui, w_is_aui, w_shift, w_f7_ok, w_legal;
  logic w_acc, w_fire, w_out_dec, w_out_skid, w_skid_ld;
  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];
  assign w_opc    = in_inst[6:0];
  assign w_f3     = in_inst[14:12];
  assign w_f7     = in_inst[31:25];
  assign w_is_op  = w_opc == 7'h33;
  assign w_is_imm = w_opc == 7'h13;
  assign w_is_lui = w_opc == 7'h37;
  assign w_is_aui = w_opc == 7'h17;
  assign w_shift  = w_f3[1:0] == 2'b01;
  // funct7 is only meaningful for register ops and immediate shifts
  assign w_f7_ok  = (w_f7 == 7'h00) | (w_f7 == 7'h20 & (w_f3 == 3'd0 | w_f3 == 3'd5));
  assign w_legal  = (w_is_op | w_is_imm | w_is_lui | w_is_aui) & (~(w_is_op | w_is_imm & w_shift) | w_f7_ok);
  always_comb begin
    w_alu_fn = 6'h00;
    case (w_f3)
      3'd0: w_alu_fn = {5'b01000, w_is_op & w_f7[5]};
      3'd1: w_alu_fn = 6'h30;
      3'd2: w_alu_fn = 6'h05;
      3'd3: w_alu_fn = 6'h07;
      3'd4: w_alu_fn = 6'h26;
      3'd5: w_alu_fn = {4'b1100, w_f7[5], 1'b1};
      3'd6: w_alu_fn = 6'h2E;
      3'd7: w_alu_fn = 6'h28;
    endcase
  end
  assign w_fn   = (w_is_lui | w_is_aui) ? 6'h10 : w_alu_fn;
  assign w_src1 = w_is_lui ? '0 : w_is_aui ? in_pc : rs1_data;
  assign w_src2 = w_is_op  ? rs2_data
                : w_is_imm ? (w_shift ? {{(XLEN-5){1'b0}}, in_inst[24:20]} : {{(XLEN-12){in_inst[31]}}, in_inst[31:20]})
                : {in_inst[31:12], 12'b0};
  assign w_dec  = w_legal ? {1'b0, in_inst[11:7] != 5'd0, in_inst[11:7], w_fn, w_src2, w_src1}
                          : {1'b1, {(PW-1){1'b0}}};
  assign w_acc  = in_valid & in_ready;
  assign w_fire = ex_valid & ex_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == EMPTY) ? (w_acc ? ONE : EMPTY)
           : (r_state == ONE)   ? ((w_acc & ~w_fire) ? TWO : (w_fire & ~w_acc) ? EMPTY : ONE)
           : (w_fire ? ONE : TWO);
  end
  always_comb begin
    ex_valid = r_state != EMPTY;
    in_ready = SKID ? (r_state != TWO) : (r_state == EMPTY | ex_ready);
  end
  // FIFO order: a new op lands in the out reg only if it is empty or draining this cycle
  assign w_out_dec  = w_acc & (r_state == EMPTY | w_fire);
  assign w_out_skid = (r_state == TWO) & w_fire;
  assign w_skid_ld  = w_acc & (r_state == ONE) & ~w_fire;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      if (w_out_dec | w_out_skid) r_out <= w_out_skid ? r_skid : w_dec;
      if (w_skid_ld) r_skid <= w_dec;
    end
  end
  assign {ex_illegal, ex_wen, ex_rd, ex_fn, ex_src2, ex_src1} = r_out;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: random and directed stimulus against a queue-based reference of the issue stage.
module tb_alu_issue;
  logic        clk = 0, rst_n = 0, in_valid = 0, ex_ready = 0;
  logic [31:0] in_inst = 0, in_pc = 0, rs1_data, rs2_data, ex_src1, ex_src2;
  logic [4:0]  rs1_addr, rs2_addr, ex_rd;
  logic [5:0]  ex_fn;
  logic        in_ready, ex_valid, ex_wen, ex_illegal;
  logic [31:0] rf [32];
  logic [5:0]  fn_tab [8];
  logic [76:0] q [$];
  logic [31:0] cur_inst, cur_pc;
  int total = 0, bad = 0, issued = 0;

  alu_issue #(.XLEN(32), .SKID(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_src1(ex_src1),
    .ex_src2(ex_src2), .ex_fn(ex_fn), .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_illegal(ex_illegal)
  );

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [76:0] got, input logic [76:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] gen();
    logic [31:0] r;
    logic [6:0]  f7;
    logic [4:0]  rd;
    r  = $urandom;
    rd = ($urandom_range(0, 3) == 0) ? 5'd0 : r[11:7];
    f7 = ($urandom_range(0, 3) == 0) ? r[31:25] : ($urandom_range(0, 1) == 1 ? 7'h20 : 7'h00);
    case ($urandom_range(0, 5))
      0, 1:    return {f7, r[24:12], rd, 7'h33};
      2, 3:    return {f7, r[24:12], rd, 7'h13};
      4:       return {r[31:12], rd, ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17};
      default: return r;
    endcase
  endfunction

  // Expected issue payload derived directly from the instruction-set rules
  function automatic logic [76:0] exp_of(input logic [31:0] i, input logic [31:0] pc);
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [5:0]  fn;
    logic [31:0] a, b;
    bit ok, sh;
    f7 = i[31:25]; f3 = i[14:12]; sh = (f3 == 3'd1) || (f3 == 3'd5);
    ok = 0; a = 0; b = 0; fn = 0;
    if (i[6:0] == 7'h33) begin
      ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      a = rf[i[19:15]]; b = rf[i[24:20]];
      fn = fn_tab[f3] + ((f7 == 7'h20) ? ((f3 == 3'd0) ? 6'd1 : 6'd2) : 6'd0);
    end else if (i[6:0] == 7'h13) begin
      ok = !sh || f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5);
      a = rf[i[19:15]];
      b = sh ? 32'(i[24:20]) : 32'($signed(i[31:20]));
      fn = fn_tab[f3] + ((sh && f7 == 7'h20) ? 6'd2 : 6'd0);
    end else if (i[6:0] == 7'h37 || i[6:0] == 7'h17) begin
      ok = 1;
      a = (i[6:0] == 7'h17) ? pc : 32'd0;
      b = {i[31:12], 12'h000};
      fn = 6'h10;
    end
    return ok ? {1'b0, i[11:7] != 5'd0, i[11:7], fn, b, a} : {1'b1, 76'd0};
  endfunction

  task automatic next_inst();
    cur_inst = gen();
    cur_pc   = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic step(input bit v, input bit r);
    bit acc, fire;
    @(negedge clk);
    chk("in_ready", in_ready, q.size() < 2);
    chk("ex_valid", ex_valid, q.size() != 0);
    if (q.size() != 0) chk("payload", {ex_illegal, ex_wen, ex_rd, ex_fn, ex_src2, ex_src1}, q[0]);
    in_valid = v; ex_ready = r; in_inst = cur_inst; in_pc = cur_pc;
    #1;
    chk("rs_addr", {rs2_addr, rs1_addr}, {cur_inst[24:20], cur_inst[19:15]});
    acc  = v && q.size() < 2;
    fire = r && q.size() != 0;
    if (fire) begin
      void'(q.pop_front());
      issued++;
    end
    if (acc) begin
      q.push_back(exp_of(cur_inst, cur_pc));
      next_inst();
    end
  endtask

  task automatic flush();
    repeat (4) if (q.size() != 0) step(0, 1);
  endtask

  task automatic one(input logic [31:0] inst, input logic [31:0] pc);
    flush();
    cur_inst = inst; cur_pc = pc;
    step(1, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    fn_tab = '{6'h10, 6'h30, 6'h05, 6'h07, 6'h26, 6'h31, 6'h2E, 6'h28};
    foreach (rf[k]) rf[k] = $urandom;
    rf[1] = 32'h10;
    next_inst();
    #12;
    chk("rst_ready", in_ready, 1);
    chk("rst_outs", {ex_valid, ex_illegal, ex_wen, ex_rd, ex_fn, ex_src2, ex_src1}, 0);
    @(negedge clk);
    rst_n = 1;

    one(32'hFFF08293, 32'h0);
    chk("addi_src1", ex_src1, 32'h10);
    chk("addi_src2", ex_src2, 32'hFFFFFFFF);
    chk("addi_fn_rd_wen", {ex_fn, ex_rd, ex_wen, ex_illegal}, {6'h10, 5'd5, 1'b1, 1'b0});
    one(32'h4041D193, 32'h0);
    chk("srai", {ex_fn, ex_src2}, {6'h33, 32'd4});
    one(32'h40208033, 32'h0);
    chk("sub_x0", {ex_fn, ex_wen}, {6'h11, 1'b0});
    one(32'h12345097, 32'h80000000);
    chk("auipc", {ex_src1, ex_src2}, {32'h80000000, 32'h12345000});
    one(32'h0000A083, 32'h0);
    chk("load_ill", {ex_illegal, ex_fn, ex_wen, ex_src1, ex_src2}, {1'b1, 71'd0});
    one(32'h023100B3, 32'h0);
    chk("mul_ill", {ex_illegal, ex_fn, ex_wen, ex_src1, ex_src2}, {1'b1, 71'd0});

    flush();
    repeat (3) step(1, 0);
    @(posedge clk);
    #1;
    chk("bp_ready", {in_ready, ex_valid}, 2'b01);
    repeat (6) step(1, 1);

    flush();
    issued = 0;
    for (int i = 0; i < 100; i++) begin
      step(1, 1);
      if (i > 0) chk("stream_flow", {ex_valid, in_ready}, 2'b11);
    end
    step(0, 1);
    chk("stream_count", issued, 100);

    repeat (400) step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);

    flush();
    step(1, 0);
    step(1, 0);
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("midrst_ready", in_ready, 1);
    chk("midrst_outs", {ex_valid, ex_illegal, ex_wen, ex_rd, ex_fn, ex_src2, ex_src1}, 0);
    q.delete();
    in_valid = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("post_rst_valid", ex_valid, 0);
    repeat (50) step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
